mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store initiator driving the word-addressed, byte-strobed single-write/dual-read memory port from the CPU side. Accepts one byte/half/word load or store request per transaction over a valid/ready handshake, checks alignment, generates the word address, byte strobes and lane-replicated write data, and returns sign- or zero-extended load data over a valid/ready response channel. Sits between the CPU execute/memory stage and the data-side port of the memory.

## Interface
- ADDR_WIDTH, 14, byte-address width; the memory word address is ADDR_WIDTH-2 bits

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_waddr  out  ADDR_WIDTH-2  memory write word address
- mem_raddr  out  ADDR_WIDTH-2  memory read word address
- mem_wren  out  1  memory write enable; write commits on clk edge
- mem_rden  out  1  memory read enable
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte write strobes
- mem_rdata  in  32  memory read data, combinational from mem_raddr, zero when mem_rden=0

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on error.
- IDLE: req_ready=1. On handshake, register wr, size, unsigned, addr, wdata; compute err = (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0).
- ACCESS (one cycle, error-free requests only): mem_waddr = mem_raddr = addr[ADDR_WIDTH-1:2]. Store: mem_wren=1, mem_rden=0. Load: mem_rden=1, mem_wren=0; mem_rdata captured into resp_rdata at cycle end.
- Store lanes, k = addr[1:0]: byte -> mem_wstrb = 4'b0001<<k, mem_wdata = {4{wdata[7:0]}}; half -> 4'b0011<<k, {2{wdata[15:0]}}; word -> 4'hF, wdata.
- Load extraction: byte = mem_rdata[8k+7:8k]; half = mem_rdata[8k+15:8k]; extended to 32 bits per req_unsigned; word passed unchanged.
- RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready; then IDLE.
- Error: no mem_wren or mem_rden asserted, resp_err=1, resp_rdata=0.
- Outside ACCESS: mem_wren=0, mem_rden=0, mem_wstrb=0; address/wdata outputs hold the registered values.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wren=0, mem_rden=0, mem_wstrb=0, mem_wdata=0, mem_waddr=0, mem_raddr=0.
- Accept at edge N: ACCESS during cycle N+1, resp_valid from cycle N+2; error resp_valid from cycle N+1.
- Store data visible in memory after edge ending ACCESS.
- resp_ready high on first RESP cycle: req_ready high next cycle; minimum issue interval 3 cycles (2 for errors).
- req_valid outside IDLE is ignored; no queuing.
- Async reset at any time: immediate IDLE, mem_wren/mem_rden drop without waiting for clk, in-flight store not committed, pending response discarded.

## Structure
- Package mem_lsu_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state encoding.
- Sub-module mem_lane_align (combinational): size + addr[1:0] + wdata -> wstrb/wdata; size + unsigned + addr[1:0] + rdata -> extended load data.

## Test plan
- sw 0x0010, 0xDEADBEEF -> ACCESS: mem_waddr=4, mem_wstrb=4'hF, mem_wren=1; resp_valid at N+2, resp_err=0, resp_rdata=0.
- sb 0x0013, 0x000000A5 -> mem_wstrb=4'b1000, mem_wdata=0xA5A5A5A5; then lw 0x0010 -> 0xA5ADBEEF.
- lb 0x0013 -> 0xFFFFFFA5; lbu 0x0013 -> 0x000000A5; lh 0x0012 -> 0xFFFFA5AD; lhu 0x0010 -> 0x0000BEEF.
- lw 0x0011, sh 0x0001, size=3 -> resp_err=1, resp_rdata=0, resp_valid at N+1, mem_wren and mem_rden never asserted, memory unchanged.
- resp_ready low for 3 cycles -> resp_valid/resp_rdata stable, req_ready=0, concurrent req_valid ignored; accepted after resp_ready.
- rst asserted mid-ACCESS of sw 0x0020 -> mem_wren low immediately, word 8 unchanged, all outputs at reset values.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment check used when a request is accepted.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // A request is rejected when its size is illegal or its address is not
    // naturally aligned to that size.
    function automatic logic req_bad(input size_t size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the CPU's right-aligned data and the 32-bit
// memory word: store strobes/replicated data, and load extraction/extension.
module mem_lane_align
    import mem_lsu_pkg::*;
(
    input  logic        [1:0]  size,
    input  logic        [1:0]  offset,
    input  logic               is_unsigned,
    input  logic        [31:0] wdata,
    input  logic        [31:0] rdata,
    output logic        [3:0]  wstrb,
    output logic        [31:0] wdata_lanes,
    output logic        [31:0] load_data
);

    logic [31:0] shifted;

    // Store path: strobe the addressed lanes and replicate data across them.
    always_comb begin
        wstrb       = '0;
        wdata_lanes = wdata;
        case (size_t'(size))
            SZ_BYTE: begin
                wstrb       = 4'b0001 << offset;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wstrb       = 4'b0011 << offset;
                wdata_lanes = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                wstrb       = 4'hF;
                wdata_lanes = wdata;
            end
            default: begin
                wstrb       = '0;
                wdata_lanes = wdata;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        load_data = rdata;
        case (size_t'(size))
            SZ_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: one request at a time, IDLE -> ACCESS -> RESP,
// with misaligned/illegal requests going straight to RESP with an error.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-3:0] mem_waddr,
    output logic [ADDR_WIDTH-3:0] mem_raddr,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata
);

    state_t      state;
    logic        wr_q;
    size_t       size_q;
    logic        uns_q;
    logic [1:0]  off_q;

    logic [1:0]  sel_size;
    logic [1:0]  sel_off;
    logic        sel_uns;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        bad;

    // The single lane aligner serves the store path from the live request
    // while idle, and the load path from the registered request in ACCESS.
    always_comb begin
        sel_size = (state == ST_IDLE) ? req_size     : size_q;
        sel_off  = (state == ST_IDLE) ? req_addr[1:0] : off_q;
        sel_uns  = (state == ST_IDLE) ? req_unsigned : uns_q;
        bad      = req_bad(size_t'(req_size), req_addr[1:0]);
    end

    mem_lane_align u_align (
        .size        (sel_size),
        .offset      (sel_off),
        .is_unsigned (sel_uns),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .wstrb       (lane_wstrb),
        .wdata_lanes (lane_wdata),
        .load_data   (load_data)
    );

    // Transaction FSM with all handshake and memory-port outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            off_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_waddr  <= '0;
            mem_raddr  <= '0;
            mem_wren   <= 1'b0;
            mem_rden   <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_wr;
                        size_q     <= size_t'(req_size);
                        uns_q      <= req_unsigned;
                        off_q      <= req_addr[1:0];
                        mem_waddr  <= req_addr[ADDR_WIDTH-1:2];
                        mem_raddr  <= req_addr[ADDR_WIDTH-1:2];
                        mem_wdata  <= lane_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= bad;
                        if (bad) begin
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            mem_wren  <= req_wr;
                            mem_rden  <= !req_wr;
                            mem_wstrb <= req_wr ? lane_wstrb : 4'h0;
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_wren   <= 1'b0;
                    mem_rden   <= 1'b0;
                    mem_wstrb  <= '0;
                    if (!wr_q) begin
                        resp_rdata <= load_data;
                    end
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small byte-strobed memory model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] mem_waddr;
    logic [11:0] mem_raddr;
    logic        mem_wren;
    logic        mem_rden;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int tests = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_WIDTH(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_waddr    (mem_waddr),
        .mem_raddr    (mem_raddr),
        .mem_wren     (mem_wren),
        .mem_rden     (mem_rden),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    // Memory model: strobed write on the clock edge, gated combinational read.
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end
    assign mem_rdata = mem_rden ? mem[mem_raddr] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"},  32'(req_ready),  32'd1);
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".resp_rdata"}, resp_rdata,      32'd0);
        check({tag, ".resp_err"},   32'(resp_err),   32'd0);
        check({tag, ".mem_wren"},   32'(mem_wren),   32'd0);
        check({tag, ".mem_rden"},   32'(mem_rden),   32'd0);
        check({tag, ".mem_wstrb"},  32'(mem_wstrb),  32'd0);
        check({tag, ".mem_wdata"},  mem_wdata,       32'd0);
        check({tag, ".mem_waddr"},  32'(mem_waddr),  32'd0);
        check({tag, ".mem_raddr"},  32'(mem_raddr),  32'd0);
    endtask

    // One complete transaction with resp_ready held high.
    task automatic run(input string tag, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [13:0] addr, input logic [31:0] wdata,
                       input logic err_e, input logic [31:0] rdata_e,
                       input logic [3:0] strb_e, input logic [31:0] wdata_e);
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_wr       = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (err_e) begin
            check({tag, ".n1_resp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".resp_err"},      32'(resp_err),   32'd1);
            check({tag, ".resp_rdata"},    resp_rdata,      32'd0);
            check({tag, ".mem_wren"},      32'(mem_wren),   32'd0);
            check({tag, ".mem_rden"},      32'(mem_rden),   32'd0);
            check({tag, ".mem_wstrb"},     32'(mem_wstrb),  32'd0);
        end else begin
            check({tag, ".mem_wren"},      32'(mem_wren),   32'(wr));
            check({tag, ".mem_rden"},      32'(mem_rden),   32'(!wr));
            check({tag, ".mem_waddr"},     32'(mem_waddr),  32'(addr[13:2]));
            check({tag, ".mem_raddr"},     32'(mem_raddr),  32'(addr[13:2]));
            check({tag, ".n1_resp_valid"}, 32'(resp_valid), 32'd0);
            if (wr) begin
                check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(strb_e));
                check({tag, ".mem_wdata"}, mem_wdata,      wdata_e);
            end
            @(negedge clk);
            check({tag, ".n2_resp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".resp_err"},      32'(resp_err),   32'd0);
            check({tag, ".resp_rdata"},    resp_rdata,      rdata_e);
            check({tag, ".resp_wren"},     32'(mem_wren),   32'd0);
            check({tag, ".resp_wstrb"},    32'(mem_wstrb),  32'd0);
        end
        @(posedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Stores and read-back
        run("sw10", 1'b1, 2'd2, 1'b0, 14'h0010, 32'hDEADBEEF, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF);
        check("mem4_sw", mem[4], 32'hDEADBEEF);
        run("sb13", 1'b1, 2'd0, 1'b0, 14'h0013, 32'h000000A5, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5);
        check("mem4_sb", mem[4], 32'hA5ADBEEF);
        run("lw10",  1'b0, 2'd2, 1'b0, 14'h0010, 32'h0, 1'b0, 32'hA5ADBEEF, 4'h0, 32'h0);
        run("lb13",  1'b0, 2'd0, 1'b0, 14'h0013, 32'h0, 1'b0, 32'hFFFFFFA5, 4'h0, 32'h0);
        run("lbu13", 1'b0, 2'd0, 1'b1, 14'h0013, 32'h0, 1'b0, 32'h000000A5, 4'h0, 32'h0);
        run("lh12",  1'b0, 2'd1, 1'b0, 14'h0012, 32'h0, 1'b0, 32'hFFFFA5AD, 4'h0, 32'h0);
        run("lhu10", 1'b0, 2'd1, 1'b1, 14'h0010, 32'h0, 1'b0, 32'h0000BEEF, 4'h0, 32'h0);
        run("lbu10", 1'b0, 2'd0, 1'b1, 14'h0010, 32'h0, 1'b0, 32'h000000EF, 4'h0, 32'h0);

        // Misaligned and illegal-size requests
        run("lw11_err", 1'b0, 2'd2, 1'b0, 14'h0011, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
        run("sh01_err", 1'b1, 2'd1, 1'b0, 14'h0001, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0);
        run("sz3_err",  1'b1, 2'd3, 1'b0, 14'h0010, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0);
        check("mem4_after_err", mem[4], 32'hA5ADBEEF);

        // Back-pressure: response held, competing request ignored until IDLE
        @(negedge clk);
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_wr       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 14'h0010;
        @(posedge clk);
        @(negedge clk);
        req_wr    = 1'b1;
        req_addr  = 14'h0020;
        req_wdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall.resp_valid", 32'(resp_valid), 32'd1);
            check("stall.resp_rdata", resp_rdata,      32'hA5ADBEEF);
            check("stall.req_ready",  32'(req_ready),  32'd0);
            check("stall.mem_wren",   32'(mem_wren),   32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall.idle_ready", 32'(req_ready),  32'd1);
        check("stall.idle_resp",  32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("stall.sw_wren",  32'(mem_wren),  32'd1);
        check("stall.sw_waddr", 32'(mem_waddr), 32'd8);
        check("stall.sw_wstrb", 32'(mem_wstrb), 32'hF);
        @(negedge clk);
        check("stall.sw_resp", 32'(resp_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("mem8_sw", mem[8], 32'h11111111);

        // Asynchronous reset in the middle of a store's ACCESS cycle
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 14'h0020;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst.pre_wren", 32'(mem_wren), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        check("mem8_after_rst", mem[8], 32'h11111111);
        rst = 1'b0;
        run("lw20", 1'b0, 2'd2, 1'b0, 14'h0020, 32'h0, 1'b0, 32'h11111111, 4'h0, 32'h0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, required finish within 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
